// File: rtl/fork_join_pkg.sv
// rtl/fork_join_pkg.sv - shared types and join-policy helper for the fork/join controller
// Purpose: join policy and FSM state enums, plus the join-condition decode
//          shared by the controller.
// Ports:   none (package).
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2,
    JOIN_RSVD = 2'd3
  } join_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Join condition while in RUN. JOIN_ANY also fires when nothing is left
  // active so an empty fork still joins; the reserved code behaves as JOIN_ALL.
  function automatic logic join_met(join_mode_t m, logic any_fin, logic none_left);
    case (m)
      JOIN_ANY:  return any_fin | none_left;
      JOIN_NONE: return 1'b1;
      default:   return none_left;
    endcase
  endfunction

endpackage

// File: rtl/fork_join_ctrl_if.sv
// rtl/fork_join_ctrl_if.sv - control/status bundle between a fork/join requester and the controller
// Purpose: groups the fork request, job configuration and status outputs.
// Ports (master drives): start, mode, kill_on_join, abort, ch_en, dur
// Ports (slave drives):  busy, ch_active, ch_done, join_done, all_done,
//                        first_idx, start_drop
interface fork_join_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  localparam int FI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    start;
  logic [1:0]              mode;
  logic                    kill_on_join;
  logic                    abort;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] dur;

  logic                    busy;
  logic [NUM_CH-1:0]       ch_active;
  logic [NUM_CH-1:0]       ch_done;
  logic                    join_done;
  logic                    all_done;
  logic [FI_W-1:0]         first_idx;
  logic                    start_drop;

  modport master (
    output start, mode, kill_on_join, abort, ch_en, dur,
    input  busy, ch_active, ch_done, join_done, all_done, first_idx, start_drop
  );

  modport slave (
    input  start, mode, kill_on_join, abort, ch_en, dur,
    output busy, ch_active, ch_done, join_done, all_done, first_idx, start_drop
  );

endinterface

// File: rtl/fj_chan_timer.sv
// rtl/fj_chan_timer.sv - per-channel job duration down-counter
// Purpose: loads a duration, counts down while enabled, pulses done on
//          natural completion; cancel clears it silently.
// Ports:   clk, rst_n (async active-low)
//          load, load_val  - arm the channel with a duration (0 treated as 1)
//          cancel          - drop the channel without a done pulse
//          count_en        - decrement enable
//          active          - channel armed and not finished/cancelled
//          done            - one-cycle completion pulse
//          finish          - channel completes at the next edge (comb)
module fj_chan_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cancel,
  input  logic             count_en,
  output logic             active,
  output logic             done,
  output logic             finish
);

  logic [CNT_W-1:0] cnt_q;

  // Counter holds the cycles still to go, so it never needs to exceed the
  // loaded value and cannot wrap.
  assign finish = active && count_en && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        cnt_q  <= '0;
        active <= 1'b0;
      end else if (load) begin
        cnt_q  <= (load_val == '0) ? CNT_W'(1) : load_val;
        active <= 1'b1;
      end else if (active && count_en) begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_q  <= '0;
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// rtl/fork_join_ctrl.sv - fork/join controller for parallel timed job channels
// Purpose: forks up to NUM_CH timed channels on start, signals the join
//          according to the latched policy, optionally kills stragglers,
//          and reports overall completion.
// Ports:   clk, rst_n (async active-low)
//          bus - fork_join_ctrl_if.slave (request/config in, status out)
module fork_join_ctrl #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fork_join_ctrl_if.slave     bus
);
  import fork_join_pkg::*;

  localparam int FI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state_q, state_d;
  join_mode_t        mode_q;
  logic              kill_q;
  logic              first_seen_q;
  logic [FI_W-1:0]   first_idx_q;
  logic              join_done_q, all_done_q, start_drop_q;

  logic [NUM_CH-1:0] act, done, fin, remaining, cancel_vec;
  logic [FI_W-1:0]   low_idx;
  logic              busy, start_acc, drop, join_fire, all_fire;

  assign busy = (state_q != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fj_chan_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_acc & bus.ch_en[i]),
      .load_val (bus.dur[i*CNT_W +: CNT_W]),
      .cancel   (cancel_vec[i]),
      .count_en (busy),
      .active   (act[i]),
      .done     (done[i]),
      .finish   (fin[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over any same-cycle join or completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.abort || all_fire) state_d = IDLE;
               else if (join_fire)        state_d = DRAIN;
      DRAIN:   if (bus.abort || all_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. remaining excludes channels finishing this edge so a
  // kill never suppresses a natural completion that lands on the join.
  always_comb begin
    remaining  = act & ~fin;
    start_acc  = 1'b0;
    drop       = 1'b0;
    join_fire  = 1'b0;
    all_fire   = 1'b0;
    cancel_vec = '0;
    case (state_q)
      IDLE: start_acc = bus.start;
      RUN: begin
        drop = bus.start;
        if (bus.abort) begin
          cancel_vec = '1;
        end else if (join_met(mode_q, |fin, remaining == '0)) begin
          join_fire = 1'b1;
          if (kill_q || remaining == '0) begin
            all_fire   = 1'b1;
            cancel_vec = remaining;
          end
        end
      end
      DRAIN: begin
        drop = bus.start;
        if (bus.abort)             cancel_vec = '1;
        else if (remaining == '0)  all_fire   = 1'b1;
      end
      default: ;
    endcase
  end

  // Lowest index among channels completing this edge
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fin[i]) low_idx = FI_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= JOIN_ALL;
      kill_q       <= 1'b0;
      first_seen_q <= 1'b0;
      first_idx_q  <= '0;
      join_done_q  <= 1'b0;
      all_done_q   <= 1'b0;
      start_drop_q <= 1'b0;
    end else begin
      join_done_q  <= join_fire;
      all_done_q   <= all_fire;
      start_drop_q <= drop;
      if (start_acc) begin
        mode_q       <= join_mode_t'(bus.mode);
        kill_q       <= bus.kill_on_join;
        first_seen_q <= 1'b0;
        first_idx_q  <= '0;
      end else if (busy && !bus.abort && (|fin) && !first_seen_q) begin
        first_seen_q <= 1'b1;
        first_idx_q  <= low_idx;
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.ch_active  = act;
  assign bus.ch_done    = done;
  assign bus.join_done  = join_done_q;
  assign bus.all_done   = all_done_q;
  assign bus.first_idx  = first_idx_q;
  assign bus.start_drop = start_drop_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// tb/tb_fork_join_ctrl.sv - self-checking bench for fork_join_ctrl
module tb_fork_join_ctrl;

  localparam int NC = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fork_join_ctrl_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  fork_join_ctrl #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: each channel is an absolute finish time (-1 = idle).
  int          fin_t [NC];
  int          s_m, e_first, n_left;
  logic        busy_m, joined_m, kill_m, first_set, hit;
  logic [1:0]  mode_m;
  logic [NC-1:0] e_done, e_act;
  logic        e_join, e_all, e_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m = 0; joined_m = 0; first_set = 0; e_first = 0;
      e_done = '0; e_act = '0; e_join = 0; e_all = 0; e_drop = 0;
      for (int i = 0; i < NC; i++) fin_t[i] = -1;
    end else begin
      cyc++;
      e_done = '0; e_join = 0; e_all = 0; e_drop = 0;
      if (!busy_m) begin
        if (bus.start) begin
          busy_m = 1; s_m = cyc; mode_m = bus.mode; kill_m = bus.kill_on_join;
          joined_m = 0; first_set = 0; e_first = 0;
          for (int i = 0; i < NC; i++) begin
            int d;
            d = int'(bus.dur[i*CW +: CW]);
            fin_t[i] = bus.ch_en[i] ? cyc + ((d == 0) ? 1 : d) : -1;
          end
        end
      end else begin
        e_drop = bus.start;
        if (bus.abort) begin
          busy_m = 0;
          for (int i = 0; i < NC; i++) fin_t[i] = -1;
        end else begin
          n_left = 0;
          for (int i = 0; i < NC; i++) begin
            if (fin_t[i] == cyc) begin e_done[i] = 1; fin_t[i] = -1; end
            else if (fin_t[i] > cyc) n_left++;
          end
          if (e_done != '0 && !first_set) begin
            first_set = 1;
            for (int i = NC - 1; i >= 0; i--) if (e_done[i]) e_first = i;
          end
          if (!joined_m) begin
            case (mode_m)
              2'd1:    hit = (e_done != '0) || (n_left == 0);
              2'd2:    hit = (cyc == s_m + 1);
              default: hit = (n_left == 0);
            endcase
            if (hit) begin
              e_join = 1; joined_m = 1;
              if (n_left == 0 || kill_m) begin
                e_all = 1; busy_m = 0;
                for (int i = 0; i < NC; i++) fin_t[i] = -1;
              end
            end
          end else if (n_left == 0) begin
            e_all = 1; busy_m = 0;
          end
        end
      end
      for (int i = 0; i < NC; i++) e_act[i] = (fin_t[i] >= 0);
    end
  end

  // Event log filled by the compare process
  int t_join, t_all, t_drop, n_join, n_all, n_drop, n_done;
  int t_done [NC];

  task automatic clear_log();
    t_join = -1; t_all = -1; t_drop = -1;
    n_join = 0; n_all = 0; n_drop = 0; n_done = 0;
    for (int i = 0; i < NC; i++) t_done[i] = -1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",       int'(bus.busy),       int'(busy_m));
      chk("ch_active",  int'(bus.ch_active),  int'(e_act));
      chk("ch_done",    int'(bus.ch_done),    int'(e_done));
      chk("join_done",  int'(bus.join_done),  int'(e_join));
      chk("all_done",   int'(bus.all_done),   int'(e_all));
      chk("start_drop", int'(bus.start_drop), int'(e_drop));
      chk("first_idx",  int'(bus.first_idx),  e_first);
      if (bus.join_done)  begin t_join = cyc; n_join++; end
      if (bus.all_done)   begin t_all  = cyc; n_all++;  end
      if (bus.start_drop) begin t_drop = cyc; n_drop++; end
      for (int i = 0; i < NC; i++) if (bus.ch_done[i]) begin t_done[i] = cyc; n_done++; end
    end
  end

  // Called on a negedge; the start edge is the next posedge.
  task automatic go(input logic [1:0] m, input logic k, input logic [1:0] en,
                    input int d0, input int d1, output int s);
    bus.mode = m; bus.kill_on_join = k; bus.ch_en = en;
    bus.dur = {CW'(d1), CW'(d0)};
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (bus.busy && k < lim) begin @(negedge clk); k++; end
    chk("idle_timeout", int'(bus.busy), 0);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int s;

  initial begin
    bus.start = 0; bus.mode = 0; bus.kill_on_join = 0; bus.abort = 0;
    bus.ch_en = '0; bus.dur = '0;
    clear_log();
    #12;
    chk("rst_busy",       int'(bus.busy), 0);
    chk("rst_ch_active",  int'(bus.ch_active), 0);
    chk("rst_ch_done",    int'(bus.ch_done), 0);
    chk("rst_join_done",  int'(bus.join_done), 0);
    chk("rst_all_done",   int'(bus.all_done), 0);
    chk("rst_start_drop", int'(bus.start_drop), 0);
    chk("rst_first_idx",  int'(bus.first_idx), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // JOIN_ANY, no kill, ch0=20 ch1=30
    clear_log(); go(2'd1, 0, 2'b11, 20, 30, s); wait_idle(60);
    chk("any_join_t", t_join, s + 20);
    chk("any_done0_t", t_done[0], s + 20);
    chk("any_done1_t", t_done[1], s + 30);
    chk("any_all_t", t_all, s + 30);
    chk("any_first", int'(bus.first_idx), 0);
    chk("any_njoin", n_join, 1);

    // JOIN_ALL, same durations
    clear_log(); go(2'd0, 0, 2'b11, 20, 30, s); wait_idle(60);
    chk("all_join_t", t_join, s + 30);
    chk("all_all_t", t_all, s + 30);
    chk("all_done0_t", t_done[0], s + 20);
    chk("all_njoin", n_join, 1);

    // JOIN_ANY with kill
    clear_log(); go(2'd1, 1, 2'b11, 20, 30, s); wait_idle(60);
    chk("kill_join_t", t_join, s + 20);
    chk("kill_all_t", t_all, s + 20);
    chk("kill_done0_t", t_done[0], s + 20);
    chk("kill_no_done1", t_done[1], -1);

    // JOIN_NONE, equal durations
    clear_log(); go(2'd2, 0, 2'b11, 5, 5, s); wait_idle(20);
    chk("none_join_t", t_join, s + 1);
    chk("none_all_t", t_all, s + 5);
    chk("none_done0_t", t_done[0], s + 5);
    chk("none_done1_t", t_done[1], s + 5);
    chk("none_first", int'(bus.first_idx), 0);

    // JOIN_ANY where the higher channel finishes first
    clear_log(); go(2'd1, 0, 2'b11, 9, 4, s); wait_idle(20);
    chk("any_hi_join_t", t_join, s + 4);
    chk("any_hi_all_t", t_all, s + 9);
    chk("any_hi_first", int'(bus.first_idx), 1);

    // Empty fork
    clear_log(); go(2'd1, 0, 2'b00, 7, 7, s); wait_idle(10);
    chk("empty_join_t", t_join, s + 1);
    chk("empty_all_t", t_all, s + 1);
    chk("empty_first", int'(bus.first_idx), 0);

    // Duration extremes: 0 behaves as 1, max value does not wrap
    clear_log(); go(2'd0, 0, 2'b11, 0, 255, s); wait_idle(300);
    chk("dur0_done_t", t_done[0], s + 1);
    chk("dur255_all_t", t_all, s + 255);

    // Reserved mode acts as JOIN_ALL
    clear_log(); go(2'd3, 0, 2'b11, 2, 6, s); wait_idle(20);
    chk("rsvd_join_t", t_join, s + 6);
    chk("rsvd_njoin", n_join, 1);

    // Abort then restart
    clear_log(); go(2'd0, 0, 2'b11, 10, 10, s);
    wait_cyc(s + 3); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    chk("abort_idle", int'(bus.busy), 0);
    chk("abort_active", int'(bus.ch_active), 0);
    wait_cyc(s + 5);
    begin
      int s2;
      go(2'd0, 0, 2'b11, 3, 3, s2);
    end
    wait_idle(20);
    chk("restart_all_t", t_all, s + 9);
    chk("restart_done1_t", t_done[1], s + 9);
    chk("restart_nall", n_all, 1);

    // Start while busy is dropped; config unchanged; start on return-to-idle edge ignored
    clear_log(); go(2'd0, 0, 2'b11, 4, 6, s);
    wait_cyc(s + 1); bus.mode = 2'd1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("drop_pulse", int'(bus.start_drop), 1);
    wait_cyc(s + 5); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_idle(20);
    chk("drop_join_t", t_join, s + 6);
    chk("drop_count", n_drop, 2);
    chk("drop_last_t", t_drop, s + 6);

    // Asynchronous reset mid-run
    clear_log(); go(2'd0, 0, 2'b11, 10, 10, s);
    wait_cyc(s + 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_active", int'(bus.ch_active), 0);
    chk("arst_join", int'(bus.join_done), 0);
    chk("arst_all", int'(bus.all_done), 0);
    chk("arst_drop", int'(bus.start_drop), 0);
    chk("arst_first", int'(bus.first_idx), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_no_done", n_done, 0);
    chk("arst_no_all", n_all, 0);
    chk("arst_idle", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fork_join_ctrl.md
FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2, number of parallel job channels (1..16).
REQ-002 Parameter CNT_W, default 8, width of each channel duration in cycles.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  fork request, sampled in IDLE only.
REQ-006 mode  input  2  join policy latched at start: 0 JOIN_ALL, 1 JOIN_ANY, 2 JOIN_NONE, 3 reserved (treated as JOIN_ALL).
REQ-007 kill_on_join  input  1  latched at start; 1 = cancel unfinished channels when join fires.
REQ-008 abort  input  1  cancel all channels immediately.
REQ-009 ch_en  input  NUM_CH  channels to fork, latched at start.
REQ-010 dur  input  NUM_CH*CNT_W  per-channel duration, channel i at bits [i*CNT_W +: CNT_W], latched at start.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 ch_active  output  NUM_CH  channel forked and not yet finished or cancelled.
REQ-013 ch_done  output  NUM_CH  one-cycle pulse per channel on natural completion.
REQ-014 join_done  output  1  one-cycle pulse when the join condition is met.
REQ-015 first_idx  output  $clog2(NUM_CH) (min 1)  index of first-finishing channel, held until next start.
REQ-016 all_done  output  1  one-cycle pulse when no channel remains active after a fork.
REQ-017 start_drop  output  1  one-cycle pulse when start is asserted while busy.

Function
REQ-018 States: IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-019 IDLE + start: latch mode, kill_on_join, ch_en and dur; set ch_active = ch_en; go to RUN.
REQ-020 Channel i finishes max(dur_i,1) cycles after the start edge: ch_done[i] is high and ch_active[i] low in the cycle following edge start+max(dur_i,1).
REQ-021 Active channels decrement once per cycle; inactive channels hold.
REQ-022 JOIN_ALL: join_done and all_done pulse in the same cycle as the last ch_done; then IDLE.
REQ-023 JOIN_ANY: join_done pulses in the same cycle as the first ch_done.
REQ-024 JOIN_NONE: join_done pulses in the cycle after start, independent of channels.
REQ-025 JOIN_ANY/JOIN_NONE with kill_on_join=1: at join, clear every remaining ch_active without ch_done; pulse all_done in the same cycle; go to IDLE.
REQ-026 JOIN_ANY/JOIN_NONE with kill_on_join=0: after join go to DRAIN; all_done pulses with the last ch_done; then IDLE; no second join_done.
REQ-027 Simultaneous completions: all their ch_done bits pulse together; first_idx = lowest index among them.
REQ-028 ch_en all zero at start: join_done and all_done pulse together in the next cycle; return to IDLE; first_idx = 0.
REQ-029 start while busy: ignored, start_drop pulses, latched config unchanged.
REQ-030 abort in RUN/DRAIN: next cycle IDLE with ch_active = 0, no ch_done, join_done or all_done; abort has priority over same-cycle completion and over start.
REQ-031 start in the same cycle as the return to IDLE is ignored (accepted only while in IDLE).
REQ-032 Duration counters are CNT_W bits and never wrap: dur = 2^CNT_W-1 completes in exactly that many cycles.

Reset
REQ-033 rst_n low: state IDLE; ch_active, ch_done, join_done, all_done, start_drop, busy = 0; first_idx = 0; counters = 0.
REQ-034 Reset asserted mid-operation cancels all channels with no completion pulses after deassertion.

Structure
REQ-035 Package fork_join_pkg holds join_mode_t (JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_RSVD) and state_t (IDLE, RUN, DRAIN).
REQ-036 Sub-module fj_chan_timer (load, cancel, count, active, done pulse) instantiated NUM_CH times; join logic and FSM sit in fork_join_ctrl.

Verification
REQ-037 NUM_CH=2, JOIN_ANY, kill=0, dur={30,20} (ch1=30, ch0=20) -> ch_done[0] and join_done at start+20, first_idx=0; ch_done[1] and all_done at start+30.
REQ-038 Same stimulus with JOIN_ALL -> single join_done and all_done at start+30; ch_done[0] at start+20.
REQ-039 JOIN_ANY, kill=1, dur={30,20} -> join_done and all_done at start+20; ch_active=0 at start+20; no ch_done[1].
REQ-040 JOIN_NONE, dur={5,5}, kill=0 -> join_done at start+1; both ch_done and all_done at start+5; first_idx=0.
REQ-041 JOIN_ALL, dur={10,10}, abort at start+4, start re-asserted at start+6 with dur={3,3} -> IDLE at start+5 with no pulses; second run completes at start+9.
REQ-042 Busy start at start+2 -> start_drop pulse; completion timing unchanged; rst_n low at start+7 -> all outputs 0 asynchronously.
